arbiter_rr_queue: RTL

- Parametrised successor to the pulse arbiter: merges TOTAL producer channels onto one consumer bus.
- Each channel gets a DEPTH-entry FIFO, so producers can issue back-to-back pulses without waiting for the grant.
- Selectable fixed-priority or round-robin grant, explicit valid/ready output handshake, per-channel overflow flags.
- Sits between multiple command/telemetry sources and a single serial sink (UART/SPI framer).

---
 rtl/arbiter_rr_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/arbiter_rr_queue.sv
// Merges TOTAL producer channels, each buffered by a DEPTH-entry FIFO, onto one valid/ready bus.
// Grants are fixed-priority (MODE=0) or round-robin (MODE=1), one grant per IDLE/GRANT pair.
module arbiter_rr_queue #(
   parameter  int TOTAL = 4,
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   parameter  int MODE  = 1,
   localparam int SEL_W = $clog2(TOTAL)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TOTAL-1:0]       rdy,
   input  logic [TOTAL*WIDTH-1:0] bus_in,
   output logic [TOTAL-1:0]       busy,
   output logic [TOTAL-1:0]       overflow,
   output logic [WIDTH-1:0]       bus_out,
   output logic                   out_valid,
   input  logic                   out_rdy,
   output logic                   out_stb,
   output logic [SEL_W-1:0]       out_selected
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [WIDTH-1:0] mem    [TOTAL][DEPTH];
   logic [PTR_W-1:0] wr_ptr [TOTAL];
   logic [PTR_W-1:0] rd_ptr [TOTAL];
   logic [CNT_W-1:0] count  [TOTAL];

   logic [TOTAL-1:0] push;
   logic [TOTAL-1:0] pop;
   logic [TOTAL-1:0] nonempty;
   logic [0:0]       state;
   logic [SEL_W-1:0] last;
   logic [SEL_W-1:0] pick;
   logic             pick_vld;

   // busy comes from the pre-edge count, so a push to a full FIFO is dropped even if it is popped now
   always_comb begin
      for (int i = 0; i < TOTAL; i++) begin
         busy[i]     = (count[i] == CNT_W'(DEPTH));
         nonempty[i] = (count[i] != '0);
         push[i]     = rdy[i] & ~busy[i];
         pop[i]      = out_stb & (out_selected == SEL_W'(i));
      end
   end

   // Search order starts at index 0 (fixed) or just after the last grant (round-robin)
   always_comb begin
      int               idx;
      logic [SEL_W-1:0] cand;
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      cand     = '0;
      for (int k = 0; k < TOTAL; k++) begin
         if (MODE == 0) begin
            idx = k;
         end else begin
            idx = int'(last) + 1 + k;
            if (idx >= TOTAL) idx = idx - TOTAL;
         end
         cand = SEL_W'(idx);
         if (!pick_vld && nonempty[cand]) begin
            pick_vld = 1'b1;
            pick     = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < TOTAL; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= bus_in[WIDTH*i +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TOTAL; i++) begin
            wr_ptr[i]   <= '0;
            rd_ptr[i]   <= '0;
            count[i]    <= '0;
            overflow[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < TOTAL; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
            else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
            if (rdy[i] && busy[i]) overflow[i] <= 1'b1;
         end
      end
   end

   // Grant FSM: a grant is held unchanged until the consumer takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         out_selected <= '0;
         last         <= SEL_W'(TOTAL - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  state        <= ST_GRANT;
                  out_selected <= pick;
                  last         <= pick;
               end
            end
            ST_GRANT: begin
               if (out_rdy) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = (state == ST_GRANT);
   assign out_stb   = out_valid & out_rdy;
   assign bus_out   = mem[out_selected][rd_ptr[out_selected]];

endmodule
